// File: rtl/rv32_lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
// Latency and backpressure are not applicable: this file holds declarations only.
package rv32_lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Request register. The full address is kept because the load path needs addr[1:0].
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [2:0]  funct3;
  } req_t;

  function automatic logic [3:0] be_for(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_B, F3_BU: be_for = 4'b0001 << addr_lo;
      F3_H, F3_HU: be_for = 4'b0011 << {addr_lo[1], 1'b0};
      default:     be_for = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] wdata);
    case (funct3)
      F3_B:    store_data = {4{wdata[7:0]}};
      F3_H:    store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_W:        misaligned = (addr_lo != 2'b00);
      F3_H, F3_HU: misaligned = addr_lo[0];
      default:     misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv32_load_align.sv
// Selects the addressed byte or half-word lane of a read word and extends it to 32 bits.
// Latency: purely combinational. Backpressure: none, because it has no handshake.
module rv32_load_align
  import rv32_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   data = {24'h0, byte_lane};
      F3_H:    data = {{16{half_lane[15]}}, half_lane};
      F3_HU:   data = {16'h0, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/rv32_mem_lsu.sv
// MEM-stage load/store unit. Minimum latency is 3 stall cycles for a load and 2 for a store.
// Backpressure: stall_out holds the pipeline until grant/response or until the bus times out.
module rv32_mem_lsu
  import rv32_lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid_in,
  input  logic        op_we_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        stall_out,
  output logic [31:0] data_res_out,
  output logic        exc_misalign_out,
  output logic        bus_err_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_t    state, state_nxt;
  req_t          req;
  logic [CW-1:0] cnt;
  logic [31:0]   load_data;
  logic          aligned, accept, busy, at_limit, completing;

  assign aligned    = !misaligned(funct3_in, addr_in[1:0]);
  assign accept     = (state == IDLE) && op_valid_in && aligned;
  assign busy       = (state == REQ) || (state == WAIT);
  assign at_limit   = (cnt == CW'(TIMEOUT));
  assign completing = ((state == REQ) && dmem_gnt) || ((state == WAIT) && dmem_rvalid);

  // A grant or response arriving on the limit cycle still wins over the timeout.
  assign bus_err_out      = busy && at_limit && !completing;
  assign exc_misalign_out = (state == IDLE) && op_valid_in && !aligned;
  assign stall_out        = accept || busy;

  assign dmem_req   = (state == REQ);
  assign dmem_we    = req.we;
  assign dmem_addr  = {req.addr[31:2], 2'b00};
  assign dmem_be    = req.be;
  assign dmem_wdata = req.wdata;

  rv32_load_align u_load_align (
    .rdata   (dmem_rdata),
    .addr_lo (req.addr[1:0]),
    .funct3  (req.funct3),
    .data    (load_data)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = REQ;
      REQ: begin
        if (dmem_gnt)      state_nxt = req.we ? DONE : WAIT;
        else if (at_limit) state_nxt = DONE;
      end
      WAIT: if (dmem_rvalid || at_limit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      req          <= '0;
      cnt          <= '0;
      data_res_out <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req <= '{addr:   addr_in,
                 be:     be_for(funct3_in, addr_in[1:0]),
                 wdata:  store_data(funct3_in, wdata_in),
                 we:     op_we_in,
                 funct3: funct3_in};
        cnt <= '0;
      end else if (busy && !at_limit) begin
        // Saturates so that a grant on the limit cycle still times out in WAIT.
        cnt <= cnt + CW'(1);
      end
      if ((state == WAIT) && dmem_rvalid) data_res_out <= load_data;
      else if (bus_err_out)               data_res_out <= '0;
    end
  end

  a_req_hold: assert property (@(posedge clk) disable iff (rst)
    (dmem_req && !dmem_gnt && !bus_err_out) |=> (dmem_req && $stable(dmem_addr) &&
      $stable(dmem_be) && $stable(dmem_wdata) && $stable(dmem_we)));
  a_err_pulse: assert property (@(posedge clk) disable iff (rst) bus_err_out |=> !bus_err_out);
  a_done_free: assert property (@(posedge clk) disable iff (rst) (state == DONE) |-> !stall_out);

endmodule

// File: tb/tb_rv32_mem_lsu.sv
// Directed bench for rv32_mem_lsu with a responsive bus model and hand-computed expectations.
module tb_rv32_mem_lsu;
  import rv32_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, op_we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall_out, exc_misalign_out, bus_err_out;
  logic [31:0] data_res_out;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  int n_vec = 0;
  int n_miscmp = 0;

  int          ns, nr, nm, ne;
  logic        st, rwe;
  logic [31:0] ra, rw, rs;
  logic [3:0]  rb;

  always #5 clk = ~clk;

  rv32_mem_lsu #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .op_valid_in(op_valid), .op_we_in(op_we), .funct3_in(funct3),
    .addr_in(addr), .wdata_in(wdata),
    .stall_out(stall_out), .data_res_out(data_res_out),
    .exc_misalign_out(exc_misalign_out), .bus_err_out(bus_err_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One operation from issue until stall_out drops; the bus grants after gnt_dly
  // request cycles and, for loads with give_rv, answers on the following cycle.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int gnt_dly, input logic give_rv,
                        input logic spur, input logic [31:0] rd,
                        output int n_stall, output int n_req, output int n_mis, output int n_err,
                        output logic stable, output logic [31:0] q_addr, output logic [3:0] q_be,
                        output logic [31:0] q_wdata, output logic q_we, output logic [31:0] res);
    int   req_seen;
    logic rv_next, fin;
    n_stall = 0; n_req = 0; n_mis = 0; n_err = 0; stable = 1'b1;
    q_addr = '0; q_be = '0; q_wdata = '0; q_we = 1'b0; res = '0;
    req_seen = 0; rv_next = 1'b0; fin = 1'b0;
    @(posedge clk); #1;
    op_valid = 1'b1; op_we = we; funct3 = f3; addr = a; wdata = wd;
    for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
      dmem_gnt    = dmem_req && (req_seen >= gnt_dly);
      dmem_rvalid = rv_next || (spur && dmem_req);
      dmem_rdata  = rv_next ? rd : 32'hDEAD_BEEF;
      @(negedge clk);
      n_stall += int'(stall_out);
      n_mis   += int'(exc_misalign_out);
      n_err   += int'(bus_err_out);
      if (dmem_req) begin
        if (n_req == 0) begin
          q_addr = dmem_addr; q_be = dmem_be; q_wdata = dmem_wdata; q_we = dmem_we;
        end else if (dmem_addr !== q_addr || dmem_be !== q_be ||
                     dmem_wdata !== q_wdata || dmem_we !== q_we) begin
          stable = 1'b0;
        end
        n_req++;
        req_seen++;
      end
      rv_next = give_rv && dmem_gnt;
      fin = !stall_out;
      if (fin) res = data_res_out;
      @(posedge clk); #1;
    end
    op_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    chk_vec("op_finished", fin, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_we = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_vec("rst_stall", stall_out, 1'b0);
    chk_vec("rst_req", dmem_req, 1'b0);
    chk_vec("rst_we", dmem_we, 1'b0);
    chk_vec("rst_be", dmem_be, 4'h0);
    chk_vec("rst_addr", dmem_addr, 32'h0);
    chk_vec("rst_wdata", dmem_wdata, 32'h0);
    chk_vec("rst_res", data_res_out, 32'h0);
    chk_vec("rst_exc", {exc_misalign_out, bus_err_out}, 2'b00);

    // LB sign-extend, top byte lane
    run_op(1'b0, F3_B, 32'h1003, 32'h0, 0, 1'b1, 1'b0, 32'h80A5_A5A5,
           ns, nr, nm, ne, st, ra, rb, rw, rwe, rs);
    chk_vec("lb_stall", ns, 3);
    chk_vec("lb_addr", ra, 32'h1000);
    chk_vec("lb_be", rb, 4'b1000);
    chk_vec("lb_we", rwe, 1'b0);
    chk_vec("lb_res", rs, 32'hFFFF_FF80);
    chk_vec("lb_exc", nm + ne, 0);

    // LHU zero-extend, upper half
    run_op(1'b0, F3_HU, 32'h2002, 32'h0, 0, 1'b1, 1'b0, 32'hBEEF_1234,
           ns, nr, nm, ne, st, ra, rb, rw, rwe, rs);
    chk_vec("lhu_be", rb, 4'b1100);
    chk_vec("lhu_res", rs, 32'h0000_BEEF);
    chk_vec("lhu_stall", ns, 3);

    // SB with grant withheld for 4 request cycles
    run_op(1'b1, F3_B, 32'h3001, 32'h0000_00AB, 4, 1'b0, 1'b0, 32'h0,
           ns, nr, nm, ne, st, ra, rb, rw, rwe, rs);
    chk_vec("sb_wdata", rw, 32'hABAB_ABAB);
    chk_vec("sb_be", rb, 4'b0010);
    chk_vec("sb_we", rwe, 1'b1);
    chk_vec("sb_stable", st, 1'b1);
    chk_vec("sb_req_cycles", nr, 5);
    chk_vec("sb_stall", ns, 6);
    chk_vec("sb_res_held", rs, 32'h0000_BEEF);

    // Misaligned LW
    run_op(1'b0, F3_W, 32'h4002, 32'h0, 0, 1'b1, 1'b0, 32'h1111_1111,
           ns, nr, nm, ne, st, ra, rb, rw, rwe, rs);
    chk_vec("mis_lw_pulse", nm, 1);
    chk_vec("mis_lw_req", nr, 0);
    chk_vec("mis_lw_stall", ns, 0);
    chk_vec("mis_lw_res", rs, 32'h0000_BEEF);

    // LH upper half with spurious rvalid before grant
    run_op(1'b0, F3_H, 32'h5002, 32'h0, 2, 1'b1, 1'b1, 32'h8001_0000,
           ns, nr, nm, ne, st, ra, rb, rw, rwe, rs);
    chk_vec("lh_spur_res", rs, 32'hFFFF_8001);
    chk_vec("lh_spur_stall", ns, 5);

    // SW / SH immediate grant
    run_op(1'b1, F3_W, 32'h6000, 32'h1234_5678, 0, 1'b0, 1'b0, 32'h0,
           ns, nr, nm, ne, st, ra, rb, rw, rwe, rs);
    chk_vec("sw_stall", ns, 2);
    chk_vec("sw_be", rb, 4'b1111);
    chk_vec("sw_wdata", rw, 32'h1234_5678);
    run_op(1'b1, F3_H, 32'h7002, 32'h0000_CAFE, 0, 1'b0, 1'b0, 32'h0,
           ns, nr, nm, ne, st, ra, rb, rw, rwe, rs);
    chk_vec("sh_wdata", rw, 32'hCAFE_CAFE);
    chk_vec("sh_be", rb, 4'b1100);
    chk_vec("sh_addr", ra, 32'h7000);

    // LBU lane 1 and LW
    run_op(1'b0, F3_BU, 32'h8001, 32'h0, 0, 1'b1, 1'b0, 32'h0000_F100,
           ns, nr, nm, ne, st, ra, rb, rw, rwe, rs);
    chk_vec("lbu_be", rb, 4'b0010);
    chk_vec("lbu_res", rs, 32'h0000_00F1);
    run_op(1'b0, F3_W, 32'h9004, 32'h0, 1, 1'b1, 1'b0, 32'h89AB_CDEF,
           ns, nr, nm, ne, st, ra, rb, rw, rwe, rs);
    chk_vec("lw_res", rs, 32'h89AB_CDEF);
    chk_vec("lw_be", rb, 4'b1111);

    // Misaligned SH leaves the result alone
    run_op(1'b1, F3_H, 32'hA001, 32'h5555_5555, 0, 1'b0, 1'b0, 32'h0,
           ns, nr, nm, ne, st, ra, rb, rw, rwe, rs);
    chk_vec("mis_sh_pulse", nm, 1);
    chk_vec("mis_sh_req", nr, 0);
    chk_vec("mis_sh_res", rs, 32'h89AB_CDEF);

    // Reset while in WAIT, then a late response
    @(posedge clk); #1;
    op_valid = 1'b1; op_we = 1'b0; funct3 = F3_W; addr = 32'hC000;
    @(posedge clk); #1;
    dmem_gnt = 1'b1;
    @(negedge clk);
    chk_vec("rstw_req", dmem_req, 1'b1);
    @(posedge clk); #1;
    dmem_gnt = 1'b0; rst = 1'b1; op_valid = 1'b0;
    @(negedge clk);
    chk_vec("rstw_in_wait", {stall_out, dmem_req}, 2'b10);
    @(posedge clk); #1;
    rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h8000_00FF;
    @(negedge clk);
    chk_vec("rstw_req_low", dmem_req, 1'b0);
    chk_vec("rstw_stall_low", stall_out, 1'b0);
    chk_vec("rstw_addr", dmem_addr, 32'h0);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    @(negedge clk);
    chk_vec("rstw_late_rvalid", data_res_out, 32'h0);

    // Load a nonzero result, then time out on a granted LW with no response
    run_op(1'b0, F3_W, 32'hD000, 32'h0, 0, 1'b1, 1'b0, 32'h7777_0001,
           ns, nr, nm, ne, st, ra, rb, rw, rwe, rs);
    chk_vec("pre_to_res", rs, 32'h7777_0001);
    run_op(1'b0, F3_W, 32'hB000, 32'h0, 0, 1'b0, 1'b0, 32'h0,
           ns, nr, nm, ne, st, ra, rb, rw, rwe, rs);
    chk_vec("to_err_pulses", ne, 1);
    chk_vec("to_res", rs, 32'h0);
    chk_vec("to_stall", ns, 10);
    @(negedge clk);
    chk_vec("to_idle", {stall_out, dmem_req, bus_err_out}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
